axi_burst_mem_slave: RTL and testbench
======================================

// Module: axi_burst_mem_slave
// PURPOSE
//  Parametrised AXI-style burst slave backed by an internal register-file memory; next generation of the Slave used with Master.
//  Independent write (AW/W/B) and read (AR/R) channels, INCR and WRAP bursts, transaction ID echo, range checking with SLVERR.
//  Sits on the master's bus as a drop-in memory target for burst read/write verification and integration.
// PARAMETERS
//  DATA_W  8    data beat width (bits)
//  ADDR_W  8    address width (word address, one word = DATA_W bits)
//  ID_W    4    transaction ID width
//  LEN_W   4    burst length field width; beats = len+1
//  DEPTH   256  number of memory words; valid addresses 0..DEPTH-1 (DEPTH <= 2**ADDR_W)
// PORTS
//  clk      in   1       clock, all logic on rising edge
//  rst      in   1       synchronous, active-high reset
//  awvalid  in   1       write address valid
//  awready  out  1       write address ready
//  awaddr   in   ADDR_W  first beat word address
//  awid     in   ID_W    write transaction ID
//  awlen    in   LEN_W   write beats minus one
//  awburst  in   1       0=INCR, 1=WRAP
//  wvalid   in   1       write data valid
//  wready   out  1       write data ready
//  wdata    in   DATA_W  write data beat
//  wlast    in   1       final write beat marker
//  bvalid   out  1       write response valid
//  bready   in   1       write response ready
//  bid      out  ID_W    echoed awid
//  bresp    out  2       00=OKAY, 10=SLVERR
//  arvalid  in   1       read address valid
//  arready  out  1       read address ready
//  araddr   in   ADDR_W  first beat word address
//  arid     in   ID_W    read transaction ID
//  arlen    in   LEN_W   read beats minus one
//  arburst  in   1       0=INCR, 1=WRAP
//  rvalid   out  1       read data valid
//  rready   in   1       read data ready
//  rdata    out  DATA_W  read data beat (registered)
//  rid      out  ID_W    echoed arid
//  rresp    out  2       per-beat 00=OKAY, 10=SLVERR
//  rlast    out  1       final read beat marker
// BEHAVIOUR
//  Reset: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0; bid/rid/bresp/rresp/rdata=0; both FSMs idle; memory NOT cleared.
//  Handshake: transfer when valid&&ready on the same edge; valid outputs held stable until accepted.
//  Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE:
//   W_IDLE: awready=1; on AW handshake latch addr/id/len/burst, clear beat count and err flag, awready=0, go W_DATA.
//   W_DATA: wready=1; each W handshake writes mem[addr] if addr<DEPTH (else drop, set err); advance addr; count++.
//   wlast must equal (count==len); mismatch sets err. Burst ends on beat count==len regardless of wlast.
//   W_RESP: bvalid=1, bid=latched id, bresp=err?10:00; on B handshake go W_IDLE, awready=1 next cycle.
//  Read FSM R_IDLE->R_DATA->R_IDLE:
//   R_IDLE: arready=1; on AR handshake latch fields; first beat presented next cycle (latency 1).
//   R_DATA: rvalid=1, rid=latched id, rlast=(count==len); rdata=mem[addr], rresp=00 if addr<DEPTH else rdata=0, rresp=10.
//   On R handshake: next beat loaded and presented next cycle (1 beat/cycle sustained); after last beat go R_IDLE, arready=1.
//  Address advance: INCR addr+1 mod 2**ADDR_W; WRAP addr=(addr&~len)|((addr+1)&len), zero-extended len.
//  WRAP with len not in {1,3,7,15,...} (len+1 not power of 2): burst executes as INCR, all responses SLVERR.
//  Simultaneous same-address write and read beat: read returns pre-write contents; write lands that edge.
//  Write and read channels fully independent; both may be active concurrently.
//  rst mid-burst: both FSMs to idle next edge, outstanding bursts abandoned, no B/R issued; completed writes retained.
// TESTING
//  Reset: rst=1 2 cycles -> awready=1, arready=1, bvalid=0, rvalid=0, wready=0.
//  INCR write awaddr=0x01 awlen=3 data 01,02,03,04 wlast on beat 4 -> bresp=00, bid=awid; read back same -> 01..04, rlast on 4th.
//  WRAP write awaddr=0x06 awlen=3 data A,B,C,D -> mem[6]=A,[7]=B,[4]=C,[5]=D; WRAP read of same returns A,B,C,D.
//  DEPTH=8, INCR write addr=6 len=3 -> mem[6],[7] written, beats 3-4 dropped, bresp=10; read same -> rresp 00,00,10,10, rdata 0 on bad beats.
//  Early wlast on beat 2 of len=3 -> all 4 beats accepted, bresp=10; rready held low 5 cycles -> rvalid/rdata stable, no beat lost.
//  rst asserted mid read burst after beat 2 -> rvalid=0 next cycle, arready=1; new AR accepted and served normally.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// axi_burst_mem_slave
// AXI-style burst memory target with independent write (AW/W/B) and read
// (AR/R) channels. Supports INCR and WRAP bursts, echoes transaction IDs and
// flags out-of-range beats and malformed WRAP bursts with SLVERR.
// The memory array is never reset, so completed writes survive a reset.

module axi_burst_mem_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic [LEN_W-1:0]  awlen,
    input  logic              awburst,

    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,

    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,

    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic [LEN_W-1:0]  arlen,
    input  logic              arburst,

    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [ID_W-1:0]   rid,
    output logic [1:0]        rresp,
    output logic              rlast
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      OKAY    = 2'b00;
    localparam logic [1:0]      SLVERR  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Word address falls inside the implemented memory
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    // Burst length len+1 is a power of two, which WRAP needs to form a window
    function automatic logic len_pow2(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] lx;
        lx = {1'b0, len};
        return ((lx & (lx + (LEN_W + 1)'(1))) == '0);
    endfunction

    // Address of the following beat; WRAP keeps the upper bits and rolls the low window
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [LEN_W-1:0]  len,
                                                    input logic              wrap);
        logic [ADDR_W-1:0] lx;
        logic [ADDR_W-1:0] inc;
        lx  = ADDR_W'(len);
        inc = a + ADDR_W'(1);
        if (wrap)
            return (a & ~lx) | (inc & lx);
        else
            return inc;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t          w_state;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [LEN_W-1:0]  w_len;
    logic              w_wrap;
    logic              w_err;
    logic [LEN_W-1:0]  w_cnt;

    r_state_t          r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_wrap;
    logic              r_err;
    logic [LEN_W-1:0]  r_cnt;

    logic              w_fire;
    logic              w_is_last;
    logic              w_beat_err;
    logic              mem_we;
    logic              ar_bad_wrap;
    logic [DATA_W-1:0] ar_data;
    logic [ADDR_W-1:0] r_next;
    logic [DATA_W-1:0] r_next_data;

    assign w_fire      = (w_state == W_DATA) && wvalid && wready;
    assign w_is_last   = (w_cnt == w_len);
    assign w_beat_err  = !in_range(w_addr) || (wlast != w_is_last);
    assign mem_we      = w_fire && in_range(w_addr) && !rst;

    assign ar_bad_wrap = arburst && !len_pow2(arlen);
    assign ar_data     = in_range(araddr) ? mem[idx(araddr)] : '0;
    assign r_next      = next_addr(r_addr, r_len, r_wrap);
    assign r_next_data = in_range(r_next) ? mem[idx(r_next)] : '0;

    // Memory write port; the read side sees the old word on a same-edge collision
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx(w_addr)] <= wdata;
    end

    // Write channel FSM: accept AW, absorb len+1 beats, then issue one B response
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= OKAY;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_wrap  <= 1'b0;
            w_err   <= 1'b0;
            w_cnt   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_addr  <= awaddr;
                        w_id    <= awid;
                        w_len   <= awlen;
                        w_wrap  <= awburst && len_pow2(awlen);
                        w_err   <= awburst && !len_pow2(awlen);
                        w_cnt   <= '0;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_len, w_wrap);
                        w_cnt  <= w_cnt + LEN_W'(1);
                        if (w_beat_err)
                            w_err <= 1'b1;
                        if (w_is_last) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= (w_err || w_beat_err) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid && bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    awready <= 1'b1;
                    wready  <= 1'b0;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: registered beat presentation, one beat per cycle while rready holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rid     <= '0;
            rresp   <= OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_addr  <= araddr;
                        r_len   <= arlen;
                        r_wrap  <= arburst && len_pow2(arlen);
                        r_err   <= ar_bad_wrap;
                        r_cnt   <= '0;
                        rid     <= arid;
                        rdata   <= ar_data;
                        rresp   <= (ar_bad_wrap || !in_range(araddr)) ? SLVERR : OKAY;
                        rlast   <= (arlen == '0);
                        rvalid  <= 1'b1;
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_next;
                            rdata  <= r_next_data;
                            rresp  <= (r_err || !in_range(r_next)) ? SLVERR : OKAY;
                            rlast  <= ((r_cnt + LEN_W'(1)) == r_len);
                            r_cnt  <= r_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                    rlast   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// tb_axi_burst_mem_slave
// Directed bench for axi_burst_mem_slave built with DEPTH=8 so that the
// out-of-range path is reachable with small addresses.

module tb_axi_burst_mem_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       awvalid;
    logic       awready;
    logic [7:0] awaddr;
    logic [3:0] awid;
    logic [3:0] awlen;
    logic       awburst;
    logic       wvalid;
    logic       wready;
    logic [7:0] wdata;
    logic       wlast;
    logic       bvalid;
    logic       bready;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic       arvalid;
    logic       arready;
    logic [7:0] araddr;
    logic [3:0] arid;
    logic [3:0] arlen;
    logic       arburst;
    logic       rvalid;
    logic       rready;
    logic [7:0] rdata;
    logic [3:0] rid;
    logic [1:0] rresp;
    logic       rlast;

    int total = 0;
    int bad   = 0;

    localparam int TIMEOUT = 20;

    axi_burst_mem_slave #(
        .DATA_W(8),
        .ADDR_W(8),
        .ID_W  (4),
        .LEN_W (4),
        .DEPTH (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .awvalid(awvalid),
        .awready(awready),
        .awaddr (awaddr),
        .awid   (awid),
        .awlen  (awlen),
        .awburst(awburst),
        .wvalid (wvalid),
        .wready (wready),
        .wdata  (wdata),
        .wlast  (wlast),
        .bvalid (bvalid),
        .bready (bready),
        .bid    (bid),
        .bresp  (bresp),
        .arvalid(arvalid),
        .arready(arready),
        .araddr (araddr),
        .arid   (arid),
        .arlen  (arlen),
        .arburst(arburst),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rid    (rid),
        .rresp  (rresp),
        .rlast  (rlast)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write burst: AW handshake, up to four beats, then B response check
    task automatic apply_stimulus(input string tag, input logic [7:0] addr,
                                  input logic [3:0] id, input logic [3:0] len,
                                  input logic burst, input logic [3:0][7:0] data,
                                  input logic [3:0] last_mask, input logic [1:0] exp_resp);
        int n;
        awaddr  = addr;
        awid    = id;
        awlen   = len;
        awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check_output({tag, "_awready"}, awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = data[i];
            wlast  = last_mask[i];
            wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
            if (wready !== 1'b1)
                check_output({tag, "_wready"}, wready, 1);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check_output({tag, "_bvalid"}, bvalid, 1);
        check_output({tag, "_bid"}, bid, id);
        check_output({tag, "_bresp"}, bresp, exp_resp);
        tick();
        bready = 1'b0;
    endtask

    task automatic do_ar(input string tag, input logic [7:0] addr, input logic [3:0] id,
                         input logic [3:0] len, input logic burst);
        int n;
        araddr  = addr;
        arid    = id;
        arlen   = len;
        arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check_output({tag, "_arready"}, arready, 1);
        tick();
        arvalid = 1'b0;
    endtask

    // Accept one read beat; rready is left high so consecutive calls stream
    task automatic get_r(input string tag, input logic [3:0] exp_id, input logic [7:0] exp_data,
                         input logic [1:0] exp_resp, input logic exp_last);
        int n;
        rready = 1'b1;
        n = 0;
        while (rvalid !== 1'b1 && n < TIMEOUT) begin tick(); n++; end
        check_output({tag, "_rvalid"}, rvalid, 1);
        check_output({tag, "_rdata"}, rdata, exp_data);
        check_output({tag, "_rresp"}, rresp, exp_resp);
        check_output({tag, "_rlast"}, rlast, exp_last);
        check_output({tag, "_rid"}, rid, exp_id);
        tick();
    endtask

    // Directed sequence
    initial begin
        rst     = 1'b1;
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awburst = 1'b0;
        wvalid  = 1'b0; wdata  = '0; wlast = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arburst = 1'b0;
        rready  = 1'b0;

        tick();
        tick();
        check_output("rst_awready", awready, 1);
        check_output("rst_arready", arready, 1);
        check_output("rst_bvalid", bvalid, 0);
        check_output("rst_rvalid", rvalid, 0);
        check_output("rst_wready", wready, 0);
        check_output("rst_rlast", rlast, 0);
        rst = 1'b0;
        tick();

        $display("[TB] INCR write/read");
        apply_stimulus("incr_wr", 8'h01, 4'h3, 4'd3, 1'b0,
                       {8'h04, 8'h03, 8'h02, 8'h01}, 4'b1000, 2'b00);
        do_ar("incr_rd", 8'h01, 4'h9, 4'd3, 1'b0);
        get_r("incr_b0", 4'h9, 8'h01, 2'b00, 1'b0);
        get_r("incr_b1", 4'h9, 8'h02, 2'b00, 1'b0);
        get_r("incr_b2", 4'h9, 8'h03, 2'b00, 1'b0);
        get_r("incr_b3", 4'h9, 8'h04, 2'b00, 1'b1);
        rready = 1'b0;
        check_output("incr_rd_done", rvalid, 0);

        $display("[TB] WRAP write/read");
        apply_stimulus("wrap_wr", 8'h06, 4'hA, 4'd3, 1'b1,
                       {8'h0D, 8'h0C, 8'h0B, 8'h0A}, 4'b1000, 2'b00);
        do_ar("wrap_rd", 8'h06, 4'h2, 4'd3, 1'b1);
        get_r("wrap_b0", 4'h2, 8'h0A, 2'b00, 1'b0);
        get_r("wrap_b1", 4'h2, 8'h0B, 2'b00, 1'b0);
        get_r("wrap_b2", 4'h2, 8'h0C, 2'b00, 1'b0);
        get_r("wrap_b3", 4'h2, 8'h0D, 2'b00, 1'b1);
        rready = 1'b0;
        do_ar("wrap_chk", 8'h04, 4'h1, 4'd1, 1'b0);
        get_r("wrap_m4", 4'h1, 8'h0C, 2'b00, 1'b0);
        get_r("wrap_m5", 4'h1, 8'h0D, 2'b00, 1'b1);
        rready = 1'b0;

        $display("[TB] out-of-range burst");
        apply_stimulus("oor_wr", 8'h06, 4'h4, 4'd3, 1'b0,
                       {8'h44, 8'h33, 8'h22, 8'h11}, 4'b1000, 2'b10);
        do_ar("oor_rd", 8'h06, 4'h5, 4'd3, 1'b0);
        get_r("oor_b0", 4'h5, 8'h11, 2'b00, 1'b0);
        get_r("oor_b1", 4'h5, 8'h22, 2'b00, 1'b0);
        get_r("oor_b2", 4'h5, 8'h00, 2'b10, 1'b0);
        get_r("oor_b3", 4'h5, 8'h00, 2'b10, 1'b1);
        rready = 1'b0;

        $display("[TB] early wlast and read stall");
        apply_stimulus("early_wr", 8'h00, 4'h6, 4'd3, 1'b0,
                       {8'h5D, 8'h5C, 8'h5B, 8'h5A}, 4'b0010, 2'b10);
        do_ar("stall_rd", 8'h00, 4'h8, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_output("stall_rvalid", rvalid, 1);
            check_output("stall_rdata", rdata, 8'h5A);
            tick();
        end
        get_r("stall_b0", 4'h8, 8'h5A, 2'b00, 1'b0);
        get_r("stall_b1", 4'h8, 8'h5B, 2'b00, 1'b0);
        get_r("stall_b2", 4'h8, 8'h5C, 2'b00, 1'b0);
        get_r("stall_b3", 4'h8, 8'h5D, 2'b00, 1'b1);
        rready = 1'b0;

        $display("[TB] reset mid read burst");
        do_ar("mid_rd", 8'h00, 4'hB, 4'd3, 1'b0);
        get_r("mid_b0", 4'hB, 8'h5A, 2'b00, 1'b0);
        get_r("mid_b1", 4'hB, 8'h5B, 2'b00, 1'b0);
        rready = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        check_output("mid_rst_rvalid", rvalid, 0);
        check_output("mid_rst_arready", arready, 1);
        check_output("mid_rst_rlast", rlast, 0);
        do_ar("post_rd", 8'h04, 4'hC, 4'd1, 1'b0);
        get_r("post_b0", 4'hC, 8'h0C, 2'b00, 1'b0);
        get_r("post_b1", 4'hC, 8'h0D, 2'b00, 1'b1);
        rready = 1'b0;

        $display("[TB] WRAP with non power-of-two length");
        apply_stimulus("badwrap_wr", 8'h01, 4'h7, 4'd2, 1'b1,
                       {8'h00, 8'hE3, 8'hE2, 8'hE1}, 4'b0100, 2'b10);
        do_ar("badwrap_rd", 8'h01, 4'hD, 4'd2, 1'b1);
        get_r("badwrap_b0", 4'hD, 8'hE1, 2'b10, 1'b0);
        get_r("badwrap_b1", 4'hD, 8'hE2, 2'b10, 1'b0);
        get_r("badwrap_b2", 4'hD, 8'hE3, 2'b10, 1'b1);
        rready = 1'b0;
        do_ar("badwrap_chk", 8'h03, 4'hE, 4'd0, 1'b0);
        get_r("badwrap_m3", 4'hE, 8'hE3, 2'b00, 1'b1);
        rready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
